// File: rtl/analysis_test_pkg.sv
// Shared types and the operand function for the analysis_pipe_test fixture.
package analysis_test_pkg;

  localparam int OP_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_AND = 2'd0,
    MODE_OR  = 2'd1,
    MODE_XOR = 2'd2,
    MODE_ADD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

  // Operands are passed at the widest supported size; callers keep the low
  // WIDTH bits, which also drops the ADD carry.
  function automatic logic [OP_MAX_W-1:0] op_apply(input mode_e mode,
                                                   input logic [OP_MAX_W-1:0] a,
                                                   input logic [OP_MAX_W-1:0] b);
    logic [OP_MAX_W-1:0] res;
    case (mode)
      MODE_AND: res = a & b;
      MODE_OR:  res = a | b;
      MODE_XOR: res = a ^ b;
      default:  res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/analysis_pipe_stage.sv
// One valid-tagged pipeline register; data only moves when a valid item arrives.
module analysis_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i && !clear;
      if (valid_i && !clear) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/analysis_pipe_test.sv
// Mode-selected operation, DEPTH-stage valid pipeline and ACC_COUNT-result accumulator.
// Optional: define ANALYSIS_PIPE_SATURATE_EN for a saturating accumulator and the sat output.
module analysis_pipe_test #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 3,
  parameter int ACC_COUNT = 4,
  parameter int ACC_WIDTH = WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic                 c_valid,
  output logic [ACC_WIDTH-1:0] d,
  output logic                 d_valid
`ifdef ANALYSIS_PIPE_SATURATE_EN
  , output logic               sat
`endif
);

  import analysis_test_pkg::*;

  localparam int CNT_W = $clog2(ACC_COUNT + 1);

  logic             accept;
  logic [WIDTH-1:0] opResult;
  logic             stageValid [DEPTH+1];
  logic [WIDTH-1:0] stageData  [DEPTH+1];

  assign in_ready = !clear;
  assign accept   = in_valid && in_ready;
  assign opResult = WIDTH'(op_apply(mode_e'(mode), OP_MAX_W'(a), OP_MAX_W'(b)));

  assign stageValid[0] = accept;
  assign stageData[0]  = opResult;

  // Entry 0 is the combinational operation result; entry k is stage k-1's output.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    analysis_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .valid_i (stageValid[k]),
      .data_i  (stageData[k]),
      .valid_o (stageValid[k+1]),
      .data_o  (stageData[k+1])
    );
  end

  assign c       = stageData[DEPTH];
  assign c_valid = stageValid[DEPTH];

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ACC_WIDTH-1:0] accStart, accNext;
  logic                 lastItem;

  assign accStart = ACC_WIDTH'(c);
  assign lastItem = (count_q + CNT_W'(1)) == CNT_W'(ACC_COUNT);

`ifdef ANALYSIS_PIPE_SATURATE_EN
  logic                 satAcc_q, satAcc_d, satOut_q, satOut_d, satStep;
  logic [ACC_WIDTH:0]   accWide;

  assign accWide = {1'b0, acc_q} + (ACC_WIDTH+1)'(c);
  assign satStep = accWide[ACC_WIDTH];
  assign accNext = satStep ? '1 : accWide[ACC_WIDTH-1:0];
`else
  assign accNext = acc_q + accStart;
`endif

  // A result arriving in DONE starts the next burst immediately, so IDLE and
  // DONE share the burst-start path.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    d_d     = d_q;
`ifdef ANALYSIS_PIPE_SATURATE_EN
    satAcc_d = satAcc_q;
    satOut_d = satOut_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (c_valid) begin
          acc_d   = accStart;
          count_d = CNT_W'(1);
          state_d = (ACC_COUNT == 1) ? ST_DONE : ST_ACCUM;
`ifdef ANALYSIS_PIPE_SATURATE_EN
          satAcc_d = 1'b0;
`endif
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (c_valid) begin
          acc_d   = accNext;
          count_d = count_q + CNT_W'(1);
`ifdef ANALYSIS_PIPE_SATURATE_EN
          satAcc_d = satAcc_q | satStep;
`endif
          if (lastItem) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (c_valid && (state_d == ST_DONE)) begin
      d_d = acc_d;
`ifdef ANALYSIS_PIPE_SATURATE_EN
      satOut_d = satAcc_d;
`endif
    end

    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
      d_d     = d_q;
`ifdef ANALYSIS_PIPE_SATURATE_EN
      satAcc_d = 1'b0;
      satOut_d = satOut_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      d_q     <= '0;
`ifdef ANALYSIS_PIPE_SATURATE_EN
      satAcc_q <= 1'b0;
      satOut_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      d_q     <= d_d;
`ifdef ANALYSIS_PIPE_SATURATE_EN
      satAcc_q <= satAcc_d;
      satOut_q <= satOut_d;
`endif
    end
  end

  assign d       = d_q;
  assign d_valid = (state_q == ST_DONE);
`ifdef ANALYSIS_PIPE_SATURATE_EN
  assign sat     = d_valid && satOut_q;
`endif

endmodule

// File: tb/tb_analysis_pipe_test.sv
// Randomised and directed bench for analysis_pipe_test against a queue-based reference model.
// Covers the ANALYSIS_PIPE_SATURATE_EN build as well as the default build.
module tb_analysis_pipe_test;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 3;
  localparam int ACC_WIDTH = 12;
`ifdef ANALYSIS_PIPE_SATURATE_EN
  localparam int ACC_CNT   = 20;
`else
  localparam int ACC_CNT   = 4;
`endif
  localparam int ACC_MAX   = (1 << ACC_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     a, b, c;
  logic                 c_valid;
  logic [ACC_WIDTH-1:0] d;
  logic                 d_valid;
`ifdef ANALYSIS_PIPE_SATURATE_EN
  logic                 sat;
`endif

  always #5 clk = ~clk;

  analysis_pipe_test #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_COUNT(ACC_CNT), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .c        (c),
    .c_valid  (c_valid),
    .d        (d),
    .d_valid  (d_valid)
`ifdef ANALYSIS_PIPE_SATURATE_EN
    , .sat    (sat)
`endif
  );

  typedef struct {
    int               due;
    logic [WIDTH-1:0] val;
  } item_t;

  item_t            pipeQ[$];
  int               cyc = 0;
  int               assertCount = 0;
  int               failCount = 0;
  int               accCnt, accSum, lastD;
  logic             accSat, lastSat, dPulse, expCValid;
  logic [WIDTH-1:0] expC;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] opModel(input logic [1:0] m, input int av, input int bv);
    case (m)
      2'd0:    return WIDTH'(av & bv);
      2'd1:    return WIDTH'(av | bv);
      2'd2:    return WIDTH'(av ^ bv);
      default: return WIDTH'((av + bv) % (1 << WIDTH));
    endcase
  endfunction

  task automatic modelReset();
    pipeQ.delete();
    expC = '0;
    expCValid = 1'b0;
    accCnt = 0;
    accSum = 0;
    accSat = 1'b0;
    lastD = 0;
    lastSat = 1'b0;
    dPulse = 1'b0;
  endtask

  // Accumulator consumes the result the model predicted for the previous
  // cycle; the pipeline is a queue of results tagged with their output cycle.
  task automatic modelEdge(input logic clr, input logic iv, input logic [1:0] m,
                           input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    item_t it;
    dPulse = 1'b0;
    if (clr) begin
      accCnt = 0;
      accSum = 0;
      accSat = 1'b0;
    end else if (expCValid) begin
      if (accCnt == 0) begin
        accSum = int'(expC);
        accSat = 1'b0;
      end else begin
        accSum = accSum + int'(expC);
        if (accSum > ACC_MAX) begin
`ifdef ANALYSIS_PIPE_SATURATE_EN
          accSum = ACC_MAX;
          accSat = 1'b1;
`else
          accSum = accSum - (ACC_MAX + 1);
`endif
        end
      end
      accCnt++;
      if (accCnt == ACC_CNT) begin
        lastD   = accSum;
        lastSat = accSat;
        dPulse  = 1'b1;
        accCnt  = 0;
      end
    end

    if (clr) begin
      pipeQ.delete();
    end else if (iv) begin
      it.due = cyc + DEPTH - 1;
      it.val = opModel(m, int'(av), int'(bv));
      pipeQ.push_back(it);
    end
    expCValid = 1'b0;
    if (pipeQ.size() > 0 && pipeQ[0].due == cyc) begin
      expC      = pipeQ[0].val;
      expCValid = 1'b1;
      void'(pipeQ.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic iv, input logic [1:0] m,
                               input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    clear    = clr;
    in_valid = iv;
    mode     = m;
    a        = av;
    b        = bv;
    @(posedge clk);
    cyc++;
    modelEdge(clr, iv, m, av, bv);
    #1;
    checkOutput("c_valid", c_valid, expCValid);
    checkOutput("c", c, expC);
    checkOutput("d_valid", d_valid, dPulse);
    checkOutput("d", d, lastD);
    checkOutput("in_ready", in_ready, !clr);
`ifdef ANALYSIS_PIPE_SATURATE_EN
    checkOutput("sat", sat, dPulse && lastSat);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  // Reset lands between clock edges and must clear the outputs without a clock.
  task automatic asyncReset();
    #2;
    in_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("rst_c", c, 0);
    checkOutput("rst_c_valid", c_valid, 0);
    checkOutput("rst_d", d, 0);
    checkOutput("rst_d_valid", d_valid, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    mode = 2'd0;
    a = '0;
    b = '0;
    modelReset();
    #12;
    checkOutput("reset_c", c, 0);
    checkOutput("reset_c_valid", c_valid, 0);
    checkOutput("reset_d", d, 0);
    checkOutput("reset_d_valid", d_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b1, 2'd0, 8'h0F, 8'h3C);
    idle(2);
    checkOutput("and_latency_valid", c_valid, 1);
    checkOutput("and_latency_c", c, 8'h0C);

    applyStimulus(1'b0, 1'b1, 2'd1, 8'hF0, 8'h0F);
    applyStimulus(1'b0, 1'b1, 2'd2, 8'hF0, 8'h0F);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'hF0, 8'h0F);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'hFF, 8'h02);
    idle(2);
    checkOutput("add_carry_c", c, 8'h01);
    idle(2);

    asyncReset();

    applyStimulus(1'b0, 1'b1, 2'd3, 8'h10, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'h20, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'h30, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'h40, 8'h00);
    idle(3);
`ifndef ANALYSIS_PIPE_SATURATE_EN
    checkOutput("burst_d_valid", d_valid, 1);
    checkOutput("burst_d", d, 12'h0A0);
    idle(1);
    checkOutput("burst_pulse_end", d_valid, 0);
`endif
    idle(3);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 2'd1, 8'hFF, 8'h00);
    idle(6);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'd3, WIDTH'(i + 1), 8'h05);
    applyStimulus(1'b1, 1'b1, 2'd3, 8'h55, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    idle(4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'd2, WIDTH'(8'h11 * (i + 1)), 8'h00);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom));
      if (i == 200) asyncReset();
    end
    idle(6);

`ifdef ANALYSIS_PIPE_SATURATE_EN
    asyncReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 2'd1, 8'hFF, 8'h00);
    idle(3);
    checkOutput("sat_d_valid", d_valid, 1);
    checkOutput("sat_d", d, 12'hFFF);
    checkOutput("sat_flag", sat, 1);
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
